keypad_entry: RTL and testbench

Consumer side of the 4x4 keypad scanner: takes the scanner's decoded key code and key-present flag, debounces them, and turns each clean press into one event. Events build up a 3-digit decimal quantity with digit, backspace, clear and confirm keys. A confirmed quantity is handed to the dispenser control as a binary value through a valid/ack handshake.

---
 rtl/keypad_entry_if.sv | 23 ++
 rtl/keypad_entry.sv | 153 +++++++++++++++
 tb/tb_keypad_entry.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// rtl/keypad_entry_if.sv - scanner key input and dispenser quantity handshake bundle
interface keypad_entry_if;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        amount_ack;
  logic [11:0] bcd;
  logic [1:0]  ndigits;
  logic [9:0]  amount;
  logic        amount_valid;
  logic        key_stb;
  logic [3:0]  key_last;
  logic        err;

  modport master (
    output key_code, key_valid, amount_ack,
    input  bcd, ndigits, amount, amount_valid, key_stb, key_last, err
  );

  modport slave (
    input  key_code, key_valid, amount_ack,
    output bcd, ndigits, amount, amount_valid, key_stb, key_last, err
  );
endinterface

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - debounced keypad events building a 3-digit quantity with valid/ack hand-off
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input logic           CLK,
  input logic           RST_N,
  keypad_entry_if.slave kp
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] WAIT_PRESS   = 2'd0;
  localparam logic [1:0] DEB_PRESS    = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;
  localparam logic [1:0] DEB_RELEASE  = 2'd3;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [3:0]    cap, cap_nx;
  logic          accept;

  logic [11:0] bcd_q, bcd_nx, bcd_base;
  logic [1:0]  nd_q, nd_nx, nd_base;
  logic [9:0]  amt_q, amt_nx;
  logic        av_q, av_nx, av_base;
  logic        err_nx, ack_hit;

  assign cnt_inc = cnt + CNT_ONE;
  assign accept  = (state == DEB_PRESS) && kp.key_valid && (kp.key_code == cap) &&
                   (cnt_inc == CNT_LAST);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap_nx   = cap;
    case (state)
      WAIT_PRESS: begin
        if (kp.key_valid) begin
          cap_nx   = kp.key_code;
          cnt_nx   = CNT_ONE;
          state_nx = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (!kp.key_valid) begin
          state_nx = WAIT_PRESS;
        end else if (kp.key_code != cap) begin
          cap_nx = kp.key_code;
          cnt_nx = CNT_ONE;
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc == CNT_LAST) state_nx = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!kp.key_valid) begin
          cnt_nx   = CNT_ONE;
          state_nx = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (kp.key_valid) begin
          state_nx = WAIT_RELEASE;
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc == CNT_LAST) state_nx = WAIT_PRESS;
        end
      end
      default: state_nx = WAIT_PRESS;
    endcase
  end

  // An ack on the same edge as a key clears the buffer first; the key then sees the cleared state.
  always_comb begin
    ack_hit  = kp.amount_ack && av_q;
    bcd_base = ack_hit ? 12'h000 : bcd_q;
    nd_base  = ack_hit ? 2'd0 : nd_q;
    av_base  = ack_hit ? 1'b0 : av_q;
    bcd_nx   = bcd_base;
    nd_nx    = nd_base;
    av_nx    = av_base;
    amt_nx   = amt_q;
    err_nx   = 1'b0;
    if (accept) begin
      if (cap <= 4'd9) begin
        if (av_base || nd_base == 2'd3) begin
          err_nx = 1'b1;
        end else begin
          bcd_nx = {bcd_base[7:0], cap};
          nd_nx  = nd_base + 2'd1;
        end
      end else begin
        case (cap)
          4'hA: begin
            if (nd_base == 2'd0 || av_base) begin
              err_nx = 1'b1;
            end else begin
              amt_nx = 10'(bcd_base[11:8]) * 10'd100 + 10'(bcd_base[7:4]) * 10'd10 +
                       10'(bcd_base[3:0]);
              av_nx  = 1'b1;
            end
          end
          4'hB: begin
            if (av_base) begin
              err_nx = 1'b1;
            end else if (nd_base != 2'd0) begin
              bcd_nx = {4'h0, bcd_base[11:4]};
              nd_nx  = nd_base - 2'd1;
            end
          end
          4'hC: begin
            bcd_nx = 12'h000;
            nd_nx  = 2'd0;
            av_nx  = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= WAIT_PRESS;
      cnt         <= '0;
      cap         <= 4'h0;
      bcd_q       <= 12'h000;
      nd_q        <= 2'd0;
      amt_q       <= 10'd0;
      av_q        <= 1'b0;
      kp.key_stb  <= 1'b0;
      kp.key_last <= 4'h0;
      kp.err      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      cap        <= cap_nx;
      bcd_q      <= bcd_nx;
      nd_q       <= nd_nx;
      amt_q      <= amt_nx;
      av_q       <= av_nx;
      kp.key_stb <= accept;
      kp.err     <= err_nx;
      if (accept) kp.key_last <= cap;
    end
  end

  assign kp.bcd          = bcd_q;
  assign kp.ndigits      = nd_q;
  assign kp.amount       = amt_q;
  assign kp.amount_valid = av_q;
endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard bench for keypad_entry with DEBOUNCE_CYCLES=4
module tb_keypad_entry;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_entry_if kp();

  keypad_entry #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .kp    (kp)
  );

  typedef struct {
    logic [3:0]  last;
    logic        err;
    logic [11:0] bcd;
    logic [1:0]  nd;
    logic [9:0]  amt;
    logic        av;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_checks = 0;
  int m_h = 0, m_t = 0, m_u = 0, m_n = 0, m_amt = 0;
  bit m_av = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (kp.err && !kp.key_stb) chk("stray_err", 1, 0);
    if (kp.key_stb) begin
      if (sb.size() == 0) begin
        chk("unexpected_stb", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("key_last", kp.key_last, e.last);
        chk("err", kp.err, e.err);
        chk("bcd", kp.bcd, e.bcd);
        chk("ndigits", kp.ndigits, e.nd);
        chk("amount", kp.amount, e.amt);
        chk("amount_valid", kp.amount_valid, e.av);
      end
    end
  endtask

  task automatic model_clear();
    m_h = 0; m_t = 0; m_u = 0; m_n = 0; m_av = 0;
  endtask

  task automatic model_key(input int code, input bit ack);
    exp_t e;
    if (ack && m_av) model_clear();
    e.err = 1'b0;
    if (code <= 9) begin
      if (m_av || m_n == 3) e.err = 1'b1;
      else begin m_h = m_t; m_t = m_u; m_u = code; m_n++; end
    end else if (code == 10) begin
      if (m_n == 0 || m_av) e.err = 1'b1;
      else begin m_amt = m_h * 100 + m_t * 10 + m_u; m_av = 1; end
    end else if (code == 11) begin
      if (m_av) e.err = 1'b1;
      else if (m_n > 0) begin m_u = m_t; m_t = m_h; m_h = 0; m_n--; end
    end else if (code == 12) begin
      model_clear();
    end
    e.last = 4'(code);
    e.bcd  = {4'(m_h), 4'(m_t), 4'(m_u)};
    e.nd   = 2'(m_n);
    e.amt  = 10'(m_amt);
    e.av   = m_av;
    sb.push_back(e);
  endtask

  // Holds the key for exactly N edges (strobe must appear on the last), then releases for N edges.
  task automatic hold_and_release(input bit ack_last);
    for (int i = 1; i <= N; i++) begin
      if (i == N) kp.amount_ack = ack_last;
      step();
      kp.amount_ack = 1'b0;
      chk($sformatf("stb_edge%0d", i), kp.key_stb, (i == N) ? 1 : 0);
    end
    kp.key_valid = 1'b0;
    for (int i = 0; i < N; i++) step();
  endtask

  task automatic press(input int code, input bit ack_last = 1'b0);
    kp.key_valid = 1'b1;
    kp.key_code  = 4'(code);
    model_key(code, ack_last);
    hold_and_release(ack_last);
  endtask

  task automatic ack_pulse();
    kp.amount_ack = 1'b1;
    step();
    kp.amount_ack = 1'b0;
    if (m_av) model_clear();
    chk("ack_av", kp.amount_valid, m_av);
    chk("ack_bcd", kp.bcd, {4'(m_h), 4'(m_t), 4'(m_u)});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bcd"}, kp.bcd, 0);
    chk({tag, "_nd"}, kp.ndigits, 0);
    chk({tag, "_amt"}, kp.amount, 0);
    chk({tag, "_av"}, kp.amount_valid, 0);
    chk({tag, "_stb"}, kp.key_stb, 0);
    chk({tag, "_last"}, kp.key_last, 0);
    chk({tag, "_err"}, kp.err, 0);
  endtask

  int bounce[5] = '{1, 0, 1, 1, 0};

  initial begin
    kp.key_valid  = 1'b0;
    kp.key_code   = 4'h0;
    kp.amount_ack = 1'b0;
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    press(1);
    chk("p1_bcd", kp.bcd, 12'h001);
    chk("p1_nd", kp.ndigits, 1);

    kp.key_code = 4'h2;
    foreach (bounce[i]) begin
      kp.key_valid = bounce[i][0];
      step();
    end
    kp.key_valid = 1'b1;
    model_key(2, 1'b0);
    hold_and_release(1'b0);
    chk("bounce_bcd", kp.bcd, 12'h012);

    press(12);
    press(1); press(2); press(3); press(4);
    chk("full_bcd", kp.bcd, 12'h123);
    press(11);
    chk("bs_bcd", kp.bcd, 12'h012);
    chk("bs_nd", kp.ndigits, 2);

    press(12);
    press(1); press(2); press(3); press(10);
    chk("conf_amt", kp.amount, 123);
    chk("conf_av", kp.amount_valid, 1);
    press(5);
    press(11);
    ack_pulse();
    chk("after_ack_bcd", kp.bcd, 0);

    press(10);
    chk("empty_conf_av", kp.amount_valid, 0);
    press(11);
    press(9); press(9); press(9); press(10);
    chk("max_amt", kp.amount, 999);
    press(12);
    chk("clr_av", kp.amount_valid, 0);
    chk("clr_amt_kept", kp.amount, 999);
    press(14);

    press(4); press(2); press(10);
    press(7, 1'b1);
    chk("ackkey_bcd", kp.bcd, 12'h007);
    chk("ackkey_av", kp.amount_valid, 0);
    press(10);
    press(12, 1'b1);
    chk("ackclr_nd", kp.ndigits, 0);
    press(3);
    ack_pulse();
    chk("idle_ack_bcd", kp.bcd, 12'h003);

    press(12);
    press(4); press(5);
    chk("pre_rst_bcd", kp.bcd, 12'h045);
    kp.key_valid = 1'b1;
    kp.key_code  = 4'h7;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk_zero("midrst");
    model_clear();
    m_amt = 0;
    rst_n = 1'b1;
    model_key(7, 1'b0);
    hold_and_release(1'b0);
    chk("post_rst_bcd", kp.bcd, 12'h007);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
